timer_ctrl: RTL and testbench

- Programmable interval-timer controller that sequences one down-counting `counter` instance as the interval counter, driven by a local prescaler.
- Supports one-shot and periodic modes.
- Each expiry is delivered as a valid/ready event; overruns are flagged.
- Sits beside peripherals and CSR blocks that need timeouts or periodic ticks, e.g. watchdogs, polling schedulers and rate limiters.

---
 rtl/timer_pkg.sv | 10 +
 rtl/timer_ctrl_counter.sv | 46 ++++
 rtl/timer_ctrl.sv | 142 ++++++++++++++
 tb/tb_timer_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types for the interval-timer controller.
//   timer_state_e : controller FSM state (IDLE = stopped, RUN = counting).
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/timer_ctrl_counter.sv
// Loadable up/down counter with wrap flag.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   clear_i      : zero the counter (highest priority)
//   load_i/d_i   : load d_i (priority over counting)
//   en_i/down_i  : count one step, down when down_i = 1
//   q_o          : registered counter value
//   overflow_o   : set on a wrap; held until clear when STICKY_OVERFLOW = 1,
//                  otherwise a one-cycle pulse
module counter #(
    parameter int unsigned WIDTH           = 16,
    parameter bit          STICKY_OVERFLOW = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic [WIDTH-1:0] q_o,
    output logic             overflow_o
);

    logic wrap;

    assign wrap = down_i ? (q_o == '0) : (q_o == '1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o        <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            q_o        <= '0;
            overflow_o <= 1'b0;
        end else if (load_i) begin
            q_o        <= d_i;
            overflow_o <= STICKY_OVERFLOW && overflow_o;
        end else if (en_i) begin
            q_o        <= down_i ? q_o - 1'b1 : q_o + 1'b1;
            overflow_o <= wrap || (STICKY_OVERFLOW && overflow_o);
        end else if (!STICKY_OVERFLOW) begin
            overflow_o <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval timer: prescaler + down-counting interval counter,
// one-shot or periodic, expiries delivered as valid/ready events.
//   clk_i/rst_ni              : clock, asynchronous active-low reset
//   start_i/stop_i            : start/restart, stop (stop has priority)
//   periodic_i/period_i/prescale_i : configuration, sampled on start
//   evt_valid_o/evt_ready_i   : expiry event handshake
//   missed_o/missed_clr_i     : sticky overrun flag and its clear
//   busy_o                    : timer running
//   count_o                   : current interval-counter value
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      periodic_i,
    input  logic [WIDTH-1:0]          period_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic                      missed_o,
    input  logic                      missed_clr_i,
    output logic                      busy_o,
    output logic [WIDTH-1:0]          count_o
);

    timer_state_e              state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [WIDTH-1:0]          period_q;
    logic                      periodic_q;

    logic running, start_cycle, tick, expiry;
    logic cnt_clear, cnt_load, cnt_en;
    logic [WIDTH-1:0] cnt_d;
    logic unused_overflow;

    assign running     = (state_q == RUN);
    assign start_cycle = start_i && !stop_i;
    assign tick        = running && (presc_q == prescale_q);
    // Any start or stop in this cycle pre-empts the expiry.
    assign expiry      = tick && (count_o == '0) && !start_i && !stop_i;

    assign cnt_clear = (running && stop_i) || (expiry && !periodic_q);
    assign cnt_load  = start_cycle || (expiry && periodic_q);
    assign cnt_d     = start_cycle ? period_i : period_q;
    assign cnt_en    = tick && (count_o != '0);

    assign busy_o = running;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        case (state_q)
            IDLE: begin
                if (start_cycle) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (start_i) begin
                    presc_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (expiry && !periodic_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q   <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
        end else if (start_cycle) begin
            period_q   <= period_i;
            prescale_q <= prescale_i;
            periodic_q <= periodic_i;
        end
    end

    // Event and overrun flags are independent of the FSM so a pending
    // event survives stop and one-shot completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_valid_o <= 1'b0;
            missed_o    <= 1'b0;
        end else begin
            if (expiry) begin
                evt_valid_o <= 1'b1;
            end else if (evt_valid_o && evt_ready_i) begin
                evt_valid_o <= 1'b0;
            end
            if (expiry && evt_valid_o && !evt_ready_i) begin
                missed_o <= 1'b1;
            end else if (missed_clr_i) begin
                missed_o <= 1'b0;
            end
        end
    end

    counter #(
        .WIDTH           (WIDTH),
        .STICKY_OVERFLOW (1'b0)
    ) i_interval_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (cnt_clear),
        .load_i     (cnt_load),
        .d_i        (cnt_d),
        .en_i       (cnt_en),
        .down_i     (1'b1),
        .q_o        (count_o),
        .overflow_o (unused_overflow)
    );

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: expected handshake cycles are queued
// by the stimulus and consumed by an independent event monitor; level
// outputs are checked directly against hand-computed values.
module tb_timer_ctrl;

    localparam int unsigned WIDTH          = 16;
    localparam int unsigned PRESCALE_WIDTH = 8;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic                      start_i, stop_i, periodic_i;
    logic [WIDTH-1:0]          period_i;
    logic [PRESCALE_WIDTH-1:0] prescale_i;
    logic                      evt_valid_o, evt_ready_i;
    logic                      missed_o, missed_clr_i;
    logic                      busy_o;
    logic [WIDTH-1:0]          count_o;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int exp_q[$];

    timer_ctrl #(
        .WIDTH          (WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .periodic_i   (periodic_i),
        .period_i     (period_i),
        .prescale_i   (prescale_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .missed_o     (missed_o),
        .missed_clr_i (missed_clr_i),
        .busy_o       (busy_o),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every accepted event must match the next queued cycle.
    always @(negedge clk_i) begin
        if (rst_ni && evt_valid_o && evt_ready_i) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL event: unexpected handshake at cycle %0d, expected none", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e != cyc) begin
                    mismatched++;
                    $display("FAIL event: handshake at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic start_cfg(input logic per, input int n, input int p);
        start_i    = 1'b1;
        periodic_i = per;
        period_i   = WIDTH'(n);
        prescale_i = PRESCALE_WIDTH'(p);
    endtask

    task automatic idle_inputs();
        start_i    = 1'b0;
        stop_i     = 1'b0;
        periodic_i = 1'b0;
        period_i   = '0;
        prescale_i = '0;
    endtask

    initial begin
        int s;
        int exp_cnt[8];
        exp_cnt = '{3, 3, 2, 2, 1, 1, 0, 0};

        rst_ni       = 1'b0;
        evt_ready_i  = 1'b1;
        missed_clr_i = 1'b0;
        idle_inputs();
        @(negedge clk_i);
        chk("reset_valid", int'(evt_valid_o), 0);
        chk("reset_missed", int'(missed_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_count", int'(count_o), 0);
        step();
        rst_ni = 1'b1;
        step();

        // Reset mid-run: N=5, P=2 periodic, reset at cycle 7.
        s = cyc;
        start_cfg(1'b1, 5, 2);
        step();
        idle_inputs();
        repeat (3) step();
        @(negedge clk_i);
        chk("midrst_count_s4", int'(count_o), 4);
        repeat (3) step();
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_count", int'(count_o), 0);
        chk("midrst_valid", int'(evt_valid_o), 0);
        step();
        rst_ni = 1'b1;
        repeat (20) step();
        @(negedge clk_i);
        chk("midrst_post_busy", int'(busy_o), 0);
        chk("midrst_post_valid", int'(evt_valid_o), 0);

        // One-shot N=3, P=1, ready held high.
        step();
        s = cyc;
        start_cfg(1'b0, 3, 1);
        exp_q.push_back(s + 9);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 1) idle_inputs();
            @(negedge clk_i);
            chk("oneshot_count", int'(count_o), exp_cnt[i-1]);
        end
        chk("oneshot_busy_s8", int'(busy_o), 1);
        step();
        @(negedge clk_i);
        chk("oneshot_busy_s9", int'(busy_o), 0);
        step();
        @(negedge clk_i);
        chk("oneshot_valid_s10", int'(evt_valid_o), 0);

        // Periodic N=2, P=0: events at s+4, s+7, s+10, s+13.
        step();
        s = cyc;
        start_cfg(1'b1, 2, 0);
        for (int k = 0; k < 4; k++) exp_q.push_back(s + 4 + 3 * k);
        step();
        idle_inputs();
        repeat (13) step();
        stop_i = 1'b1;
        @(negedge clk_i);
        chk("periodic_missed", int'(missed_o), 0);
        step();
        stop_i = 1'b0;
        @(negedge clk_i);
        chk("periodic_stop_busy", int'(busy_o), 0);

        // Periodic N=0, P=0 with ready low: overrun and missed flag.
        step();
        s = cyc;
        evt_ready_i = 1'b0;
        start_cfg(1'b1, 0, 0);
        step();
        idle_inputs();
        step();
        @(negedge clk_i);
        chk("ovr_valid_s2", int'(evt_valid_o), 1);
        chk("ovr_missed_s2", int'(missed_o), 0);
        step();
        @(negedge clk_i);
        chk("ovr_missed_s3", int'(missed_o), 1);
        step();
        missed_clr_i = 1'b1;
        step();
        missed_clr_i = 1'b0;
        stop_i       = 1'b1;
        @(negedge clk_i);
        chk("ovr_set_beats_clr", int'(missed_o), 1);
        step();
        stop_i       = 1'b0;
        evt_ready_i  = 1'b1;
        missed_clr_i = 1'b1;
        exp_q.push_back(s + 6);
        @(negedge clk_i);
        chk("ovr_busy_after_stop", int'(busy_o), 0);
        chk("ovr_valid_kept", int'(evt_valid_o), 1);
        chk("ovr_missed_sticky", int'(missed_o), 1);
        step();
        missed_clr_i = 1'b0;
        @(negedge clk_i);
        chk("ovr_missed_cleared", int'(missed_o), 0);
        chk("ovr_valid_cleared", int'(evt_valid_o), 0);

        // Start and stop together while running: stop wins.
        step();
        start_cfg(1'b1, 4, 0);
        step();
        idle_inputs();
        step();
        start_cfg(1'b1, 9, 0);
        stop_i = 1'b1;
        step();
        idle_inputs();
        @(negedge clk_i);
        chk("startstop_busy", int'(busy_o), 0);
        chk("startstop_count", int'(count_o), 0);

        // Stop in the expiry cycle: event suppressed.
        step();
        start_cfg(1'b0, 1, 0);
        step();
        idle_inputs();
        step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        @(negedge clk_i);
        chk("stopexp_busy", int'(busy_o), 0);
        chk("stopexp_count", int'(count_o), 0);
        chk("stopexp_valid", int'(evt_valid_o), 0);
        step();
        @(negedge clk_i);
        chk("stopexp_valid_late", int'(evt_valid_o), 0);

        // Restart in RUN at count 1 with N=6, one-shot.
        step();
        s = cyc;
        start_cfg(1'b1, 4, 0);
        step();
        idle_inputs();
        repeat (3) step();
        @(negedge clk_i);
        chk("restart_count_before", int'(count_o), 1);
        start_cfg(1'b0, 6, 0);
        exp_q.push_back(s + 12);
        step();
        idle_inputs();
        @(negedge clk_i);
        chk("restart_count_after", int'(count_o), 6);
        repeat (6) step();
        @(negedge clk_i);
        chk("restart_count_s11", int'(count_o), 0);
        chk("restart_busy_s11", int'(busy_o), 1);
        step();
        @(negedge clk_i);
        chk("restart_busy_s12", int'(busy_o), 0);

        repeat (4) step();
        chk("events_outstanding", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
